// File: rtl/user_prj_wb_mem.sv
// user_prj_wb_mem
// ---------------
// Wishbone slave RAM for the user-project area (mprjram window, 0x38xx_xxxx).
// Firmware copies code and data here and the CPU executes from it. To mimic a
// slow external memory, every accepted request waits a fixed number of cycles
// before it is acknowledged.
//
// Parameters:
//   ADDR_W   word-address width; depth = 2**ADDR_W 32-bit words
//   DELAYS   wait cycles between an accepted request and its ack (>= 1)
//   BASE_HI  value wbs_adr_i[31:24] must carry for the slave to respond
//
// Ports:
//   wb_clk_i   system clock
//   wb_rst_i   synchronous, active-high reset
//   wbs_cyc_i  bus cycle active
//   wbs_stb_i  request strobe
//   wbs_we_i   1 = write, 0 = read
//   wbs_sel_i  byte enables, bit n covers data[8n+7:8n]
//   wbs_adr_i  byte address
//   wbs_dat_i  write data
//   wbs_ack_o  one-cycle acknowledge
//   wbs_dat_o  read data, valid while wbs_ack_o is high, held otherwise
//
// Request sampled at edge N -> wbs_ack_o high in the cycle ending at edge
// N+DELAYS+1. One access is outstanding at a time; after every ack the slave
// spends one IDLE cycle before it can accept the next request.

module user_prj_wb_mem #(
   parameter int          ADDR_W  = 11,
   parameter int          DELAYS  = 10,
   parameter logic [7:0]  BASE_HI = 8'h38
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(DELAYS + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAYS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                ack_reg;

   // Request captured when it is accepted; bus inputs are not looked at again
   // until the FSM is back in IDLE.
   logic                we_reg;
   logic [3:0]          sel_reg;
   logic [ADDR_W-1:0]   idx_reg;
   logic [31:0]         dat_reg;

   logic                hit;
   logic                go_ack;
   logic                wr_en;
   logic                rd_en;

   // Address bits between the word index and the window byte are don't-care,
   // which makes the RAM alias across the whole 16 MB window.
   logic                unused_adr_bits;
   assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

   assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == BASE_HI);

   // Last WAIT cycle with the master still requesting: the access completes.
   // A dropped cyc/stb in that same cycle still counts as an abort.
   assign go_ack = (state_reg == ST_WAIT) && wbs_cyc_i && wbs_stb_i &&
                   (cnt_reg == CNT_ONE);

   // The RAM lanes carry no reset, so gate the enables here to make a reset
   // arriving mid-access drop the write as well.
   assign wr_en = go_ack && we_reg && !wb_rst_i;
   assign rd_en = go_ack && !we_reg;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         ack_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ack_reg <= 1'b0;
               if (hit) begin
                  cnt_reg   <= CNT_LOAD;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!wbs_cyc_i || !wbs_stb_i) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else if (cnt_reg == CNT_ONE) begin
                  cnt_reg   <= '0;
                  ack_reg   <= 1'b1;
                  state_reg <= ST_ACK;
               end else begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end
            end
            ST_ACK: begin
               ack_reg   <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               ack_reg   <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (state_reg == ST_IDLE && hit) begin
         we_reg  <= wbs_we_i;
         sel_reg <= wbs_sel_i;
         idx_reg <= wbs_adr_i[ADDR_W+1:2];
         dat_reg <= wbs_dat_i;
      end
   end

   assign wbs_ack_o = ack_reg;

   // One narrow RAM per byte lane keeps byte-enable writes a plain
   // write-enable per array, which maps cleanly onto block RAM.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_byte_reg;

         always_ff @(posedge wb_clk_i) begin
            if (wr_en && sel_reg[gi]) begin
               lane_mem[idx_reg] <= dat_reg[8*gi +: 8];
            end
         end

         // Registered read; holds its value between reads and across writes.
         always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
               rd_byte_reg <= 8'h00;
            end else if (rd_en) begin
               rd_byte_reg <= lane_mem[idx_reg];
            end
         end

         assign wbs_dat_o[8*gi +: 8] = rd_byte_reg;
      end
   endgenerate

endmodule

// File: tb/tb_user_prj_wb_mem.sv
// Testbench for user_prj_wb_mem: a Wishbone master driven from one initial
// block, a word model of the RAM, and a queue of expected read data that is
// filled when a read is issued and drained when its ack arrives.

module tb_user_prj_wb_mem;

   localparam int          ADDR_W = 11;
   localparam int          DELAYS = 10;
   localparam logic [31:0] BASE   = 32'h3800_0000;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;

   logic [31:0] model [0:(2**ADDR_W)-1];
   logic [31:0] exp_q [$];

   user_prj_wb_mem #(
      .ADDR_W  (ADDR_W),
      .DELAYS  (DELAYS),
      .BASE_HI (8'h38)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cycle_cnt = cycle_cnt + 1;

   function automatic void model_write(input logic [31:0] adr, input logic [31:0] dat,
                                       input logic [3:0] sel);
      int idx;
      idx = int'(adr[ADDR_W+1:2]);
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
      end
   endfunction

   // Drives one request from a falling edge and waits up to 'budget' edges
   // for the ack. lat = edge (counted from the request edge) at which the
   // master samples ack high; ack_next = ack one cycle later.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int budget,
                          output logic acked, output int lat,
                          output logic [31:0] rdata, output logic ack_next);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      acked = 1'b0;
      lat = 0;
      rdata = 32'h0;
      ack_next = 1'b0;
      for (int e = 0; e < budget && !acked; e++) begin
         @(posedge wb_clk_i);
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            acked = 1'b1;
            lat = e + 1;
            rdata = wbs_dat_o;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      if (acked) begin
         @(posedge wb_clk_i);
         @(negedge wb_clk_i);
         ack_next = wbs_ack_o;
      end
      $display("WB %s adr=%08h wdat=%08h sel=%b acked=%0b lat=%0d rdat=%08h",
               we ? "WR" : "RD", adr, dat, sel, acked, lat, rdata);
   endtask

   task automatic test_reset();
      wb_rst_i  = 1'b1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h0;
      wbs_dat_i = 32'h0;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checks++;
      if (wbs_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack: got %b want 0", wbs_ack_o);
      end
      checks++;
      if (wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_dat: got %08h want 00000000", wbs_dat_o);
      end
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
   endtask

   task automatic test_basic();
      logic acked, ack_next;
      int lat;
      logic [31:0] rd, exp;
      logic [31:0] vals [4];
      vals = '{32'h0000_003E, 32'h0000_0044, 32'h0000_004A, 32'h0000_0050};
      for (int i = 0; i < 4; i++) begin
         model_write(BASE + 32'(4*i), vals[i], 4'hF);
         wb_xfer(1'b1, BASE + 32'(4*i), vals[i], 4'hF, 40, acked, lat, rd, ack_next);
         checks++;
         if (!acked || ack_next !== 1'b0) begin
            errors++;
            $display("FAIL basic_wr_ack[%0d]: acked=%b next=%b want 1/0", i, acked, ack_next);
         end
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model[i]);
         wb_xfer(1'b0, BASE + 32'(4*i), 32'h0, 4'hF, 40, acked, lat, rd, ack_next);
         exp = exp_q.pop_front();
         checks++;
         if (!acked || rd !== exp) begin
            errors++;
            $display("FAIL basic_rd[%0d]: acked=%b got %08h want %08h", i, acked, rd, exp);
         end
         checks++;
         if (ack_next !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_width[%0d]: ack still %b one cycle later, want 0", i, ack_next);
         end
      end
   endtask

   task automatic test_latency();
      logic acked, ack_next;
      int lat;
      logic [31:0] rd, exp;
      exp_q.push_back(model[2]);
      wb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, 40, acked, lat, rd, ack_next);
      exp = exp_q.pop_front();
      checks++;
      if (!acked || lat != DELAYS + 1) begin
         errors++;
         $display("FAIL latency: acked=%b lat=%0d want %0d", acked, lat, DELAYS + 1);
      end
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL latency_data: got %08h want %08h", rd, exp);
      end
   endtask

   task automatic test_byte_enables();
      logic acked, ack_next;
      int lat;
      logic [31:0] rd, exp;
      logic [31:0] adr;
      adr = BASE + 32'h40;
      model_write(adr, 32'hFFFF_FFFF, 4'hF);
      wb_xfer(1'b1, adr, 32'hFFFF_FFFF, 4'hF, 40, acked, lat, rd, ack_next);
      model_write(adr, 32'h0000_AB00, 4'b0010);
      wb_xfer(1'b1, adr, 32'h0000_AB00, 4'b0010, 40, acked, lat, rd, ack_next);
      exp_q.push_back(model[16]);
      wb_xfer(1'b0, adr, 32'h0, 4'hF, 40, acked, lat, rd, ack_next);
      exp = exp_q.pop_front();
      checks++;
      if (!acked || rd !== exp) begin
         errors++;
         $display("FAIL byte_en_model: acked=%b got %08h want %08h", acked, rd, exp);
      end
      checks++;
      if (rd !== 32'hFFFF_ABFF) begin
         errors++;
         $display("FAIL byte_en_value: got %08h want FFFFABFF", rd);
      end
   endtask

   task automatic test_alias_window();
      logic acked, ack_next;
      int lat;
      logic [31:0] rd, exp;
      model_write(32'h3800_2000, 32'h1234_5678, 4'hF);
      wb_xfer(1'b1, 32'h3800_2000, 32'h1234_5678, 4'hF, 40, acked, lat, rd, ack_next);
      exp_q.push_back(model[0]);
      wb_xfer(1'b0, BASE, 32'h0, 4'hF, 40, acked, lat, rd, ack_next);
      exp = exp_q.pop_front();
      checks++;
      if (!acked || rd !== exp || rd !== 32'h1234_5678) begin
         errors++;
         $display("FAIL alias: acked=%b got %08h want %08h", acked, rd, exp);
      end
      wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 50, acked, lat, rd, ack_next);
      checks++;
      if (acked) begin
         errors++;
         $display("FAIL window: got ack after %0d cycles, want none within 50", lat);
      end
   endtask

   task automatic test_abort_reset();
      logic acked, ack_next, seen;
      int lat;
      logic [31:0] rd, exp;
      logic [31:0] adr;
      adr = BASE + 32'h80;
      model_write(adr, 32'hCAFE_F00D, 4'hF);
      wb_xfer(1'b1, adr, 32'hCAFE_F00D, 4'hF, 40, acked, lat, rd, ack_next);

      // Write that is abandoned three cycles after the request edge.
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_adr_i = adr;
      wbs_dat_i = 32'h1111_1111;
      wbs_sel_i = 4'hF;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge wb_clk_i);
         @(negedge wb_clk_i);
         if (wbs_ack_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_ack: ack seen=%b want 0", seen);
      end
      exp_q.push_back(model[32]);
      wb_xfer(1'b0, adr, 32'h0, 4'hF, 40, acked, lat, rd, ack_next);
      exp = exp_q.pop_front();
      checks++;
      if (!acked || rd !== exp) begin
         errors++;
         $display("FAIL abort_ram: acked=%b got %08h want %08h", acked, rd, exp);
      end

      // Read interrupted by reset; wbs_dat_o is non-zero going in.
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = BASE + 32'h4;
      repeat (4) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      checks++;
      if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_read: ack=%b dat=%08h want 0/00000000", wbs_ack_o, wbs_dat_o);
      end
      wb_rst_i  = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge wb_clk_i);
         @(negedge wb_clk_i);
         if (wbs_ack_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid_read_ack: ack seen=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic acked, ack_next, got;
      int lat;
      logic [31:0] rd, exp, adr, val;
      int ack_t [8];
      for (int i = 0; i < 8; i++) begin
         adr = BASE + 32'h100 + 32'(4*i);
         val = 32'hA500_0000 | (32'h0101_0101 * 32'(i + 1));
         model_write(adr, val, 4'hF);
         wb_xfer(1'b1, adr, val, 4'hF, 40, acked, lat, rd, ack_next);
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(model[64 + i]);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_adr_i = BASE + 32'h100;
      for (int i = 0; i < 8; i++) begin
         got = 1'b0;
         for (int e = 0; e < 40 && !got; e++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (wbs_ack_o) got = 1'b1;
         end
         exp = exp_q.pop_front();
         ack_t[i] = cycle_cnt;
         $display("WB RD b2b[%0d] adr=%08h acked=%0b cycle=%0d rdat=%08h",
                  i, wbs_adr_i, got, cycle_cnt, wbs_dat_o);
         checks++;
         if (!got || wbs_dat_o !== exp) begin
            errors++;
            $display("FAIL b2b_data[%0d]: acked=%b got %08h want %08h", i, got, wbs_dat_o, exp);
         end
         if (i > 0) begin
            checks++;
            if (ack_t[i] - ack_t[i-1] != DELAYS + 2) begin
               errors++;
               $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d",
                        i, ack_t[i] - ack_t[i-1], DELAYS + 2);
            end
         end
         if (i < 7) begin
            wbs_adr_i = BASE + 32'h100 + 32'(4*(i + 1));
         end else begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
         end
      end
      @(negedge wb_clk_i);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_byte_enables();
      test_alias_window();
      test_abort_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
